// File: rtl/core_run_ctrl_if.sv
// Host command handshake for core_run_ctrl: LOAD/RUN/STEP/HALT with address and data.
interface core_run_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_addr,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_addr,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/core_run_ctrl.sv
// Run controller for the single-cycle RV32I core: program load, core reset hold,
// free/bounded run, single step, and halt on breakpoint, limit or host request.
module core_run_ctrl #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    core_run_ctrl_if.slave    cmd,
    input  logic              bp_en,
    input  logic [31:0]       bp_addr,
    input  logic [31:0]       pc_in,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              core_en,
    output logic [1:0]        state,
    output logic [1:0]        halt_cause,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic              err
);
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUN     = 2'b01;
    localparam logic [1:0] ST_STEP    = 2'b10;
    localparam logic [1:0] ST_HALTED  = 2'b11;

    localparam logic [1:0] OP_LOAD    = 2'b00;
    localparam logic [1:0] OP_RUN     = 2'b01;
    localparam logic [1:0] OP_STEP    = 2'b10;
    localparam logic [1:0] OP_HALT    = 2'b11;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_LIMIT = 2'b01;
    localparam logic [1:0] CAUSE_BP    = 2'b10;
    localparam logic [1:0] CAUSE_HOST  = 2'b11;

    logic [1:0]        r_state;
    logic [1:0]        r_cause;
    logic              r_core_reset;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic              r_first;
    logic              r_halt_req;
    logic [CNT_W-1:0]  r_retired;
    logic [CNT_W-1:0]  r_run_cnt;
    logic [CNT_W-1:0]  r_limit;

    logic              w_accept;
    logic              w_bp_hit;
    logic              w_core_en;
    logic              w_lim_last;
    logic [CNT_W-1:0]  w_run_cnt_inc;

    // cmd_ready follows reset combinationally so no command can slip in during a reset cycle.
    assign cmd.cmd_ready = ~reset & (r_state != ST_STEP);
    assign w_accept      = cmd.cmd_valid & cmd.cmd_ready;

    // The breakpoint is skipped in the first RUN cycle so a resume from the breakpoint PC advances.
    assign w_bp_hit      = (r_state == ST_RUN) & bp_en & (pc_in == bp_addr) & ~r_first;
    assign w_core_en     = ((r_state == ST_RUN) & ~w_bp_hit & ~r_halt_req) | (r_state == ST_STEP);
    assign w_run_cnt_inc = r_run_cnt + CNT_W'(1);
    assign w_lim_last    = (r_state == ST_RUN) & w_core_en & (r_limit != '0) & (w_run_cnt_inc == r_limit);

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignment so every branch sees pre-edge values.
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cause      <= CAUSE_NONE;
            r_core_reset <= 1'b1;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_err        <= 1'b0;
            r_first      <= 1'b0;
            r_halt_req   <= 1'b0;
            r_retired    <= '0;
            r_run_cnt    <= '0;
            r_limit      <= '0;
        end else begin
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_first    <= 1'b0;
            r_halt_req <= 1'b0;

            if (w_core_en) begin
                if (r_retired != '1) r_retired <= r_retired + CNT_W'(1);
                if (r_run_cnt != '1) r_run_cnt <= w_run_cnt_inc;
            end

            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (w_accept) begin
                        case (cmd.cmd_op)
                            OP_LOAD: begin
                                r_we    <= 1'b1;
                                r_waddr <= cmd.cmd_addr;
                                r_wdata <= cmd.cmd_data;
                            end
                            OP_RUN: begin
                                r_state      <= ST_RUN;
                                r_core_reset <= 1'b0;
                                r_cause      <= CAUSE_NONE;
                                r_first      <= 1'b1;
                                r_run_cnt    <= '0;
                                r_limit      <= cmd.cmd_data[CNT_W-1:0];
                            end
                            OP_STEP: begin
                                r_state      <= ST_STEP;
                                r_core_reset <= 1'b0;
                                r_cause      <= CAUSE_NONE;
                            end
                            default: begin
                                if (r_state == ST_HALTED) begin
                                    r_state      <= ST_IDLE;
                                    r_core_reset <= 1'b1;
                                    r_cause      <= CAUSE_NONE;
                                    r_retired    <= '0;
                                end
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    if (w_accept && (cmd.cmd_op != OP_HALT)) r_err <= 1'b1;
                    if (w_bp_hit) begin
                        r_state <= ST_HALTED;
                        r_cause <= CAUSE_BP;
                    end else if (w_lim_last) begin
                        r_state <= ST_HALTED;
                        r_cause <= CAUSE_LIMIT;
                    end else if (r_halt_req) begin
                        r_state <= ST_HALTED;
                        r_cause <= CAUSE_HOST;
                    end else if (w_accept && (cmd.cmd_op == OP_HALT)) begin
                        r_halt_req <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_HALTED;
                    r_cause <= CAUSE_HOST;
                end
            endcase
        end
    end

    assign imem_we     = r_we;
    assign imem_waddr  = r_waddr;
    assign imem_wdata  = r_wdata;
    assign core_reset  = r_core_reset;
    assign core_en     = w_core_en;
    assign state       = r_state;
    assign halt_cause  = r_cause;
    assign retired_cnt = r_retired;
    assign err         = r_err;
endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl with a tiny PC model standing in for the core.
module tb_core_run_ctrl;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 4;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              bp_en = 1'b0;
    logic [31:0]       bp_addr = 32'd0;
    logic [31:0]       pc_in = 32'd0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              core_en;
    logic [1:0]        state;
    logic [1:0]        halt_cause;
    logic [CNT_W-1:0]  retired_cnt;
    logic              err;

    int n_pass  = 0;
    int n_total = 0;
    int en_cnt  = 0;
    int we_cnt  = 0;
    logic [31:0] mem [0:255];
    logic [31:0] prog [0:4];

    core_run_ctrl_if #(.ADDR_W(ADDR_W)) cmd_if ();

    core_run_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd         (cmd_if),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc_in       (pc_in),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .core_reset  (core_reset),
        .core_en     (core_en),
        .state       (state),
        .halt_cause  (halt_cause),
        .retired_cnt (retired_cnt),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Core stand-in: PC advances one word per enabled cycle and clears while held in reset.
    always @(posedge clk) begin
        if (core_reset === 1'b1) pc_in <= 32'd0;
        else if (core_en === 1'b1) pc_in <= pc_in + 32'd4;
    end

    always @(posedge clk) begin
        if (core_en === 1'b1) en_cnt++;
        if (imem_we === 1'b1) begin
            we_cnt++;
            mem[imem_waddr] = imem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        int waited;
        waited = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_addr  = addr;
        cmd_if.cmd_data  = data;
        while (cmd_if.cmd_ready !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        if (waited == 10) check("cmd_ready_timeout", 32'(cmd_if.cmd_ready), 32'd1);
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic run_until_stop(input int budget, output int n);
        n = 0;
        while (state == 2'b01 && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int en_base;
        int we_base;

        prog[0] = 32'h00a00293;
        prog[1] = 32'h00f2f293;
        prog[2] = 32'h0082e293;
        prog[3] = 32'h00a2f293;
        prog[4] = 32'h00028313;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_LOAD;
        cmd_if.cmd_addr  = '0;
        cmd_if.cmd_data  = '0;

        // Reset values
        tick(2);
        check("rst_ready",      32'(cmd_if.cmd_ready), 32'd0);
        check("rst_state",      32'(state),            32'd0);
        check("rst_core_reset", 32'(core_reset),       32'd1);
        check("rst_core_en",    32'(core_en),          32'd0);
        check("rst_imem_we",    32'(imem_we),          32'd0);
        check("rst_waddr",      32'(imem_waddr),       32'd0);
        check("rst_wdata",      imem_wdata,            32'd0);
        check("rst_cause",      32'(halt_cause),       32'd0);
        check("rst_retired",    32'(retired_cnt),      32'd0);
        check("rst_err",        32'(err),              32'd0);
        reset = 1'b0;
        #1;
        check("idle_ready", 32'(cmd_if.cmd_ready), 32'd1);

        // HALT in IDLE is a no-op
        issue(OP_HALT, '0, 32'd0);
        check("idle_halt_state", 32'(state), 32'd0);
        check("idle_halt_err",   32'(err),   32'd0);

        // Five back-to-back LOADs then RUN limit 5
        we_base = we_cnt;
        for (int i = 0; i < 5; i++) issue(OP_LOAD, ADDR_W'(i), prog[i]);
        check("load_last_we",    32'(imem_we),    32'd1);
        check("load_last_waddr", 32'(imem_waddr), 32'd4);
        check("load_last_wdata", imem_wdata,      prog[4]);
        tick();
        check("load_we_drop", 32'(imem_we),       32'd0);
        check("load_count",   we_cnt - we_base,   32'd5);
        for (int i = 0; i < 5; i++) check("load_mem", mem[i], prog[i]);

        en_base = en_cnt;
        issue(OP_RUN, '0, 32'd5);
        check("run_state",      32'(state),      32'd1);
        check("run_core_reset", 32'(core_reset), 32'd0);
        check("run_core_en",    32'(core_en),    32'd1);
        run_until_stop(20, n);
        check("lim_cycles",  n,                   32'd5);
        check("lim_en",      en_cnt - en_base,    32'd5);
        check("lim_state",   32'(state),          32'd3);
        check("lim_cause",   32'(halt_cause),     32'd1);
        check("lim_retired", 32'(retired_cnt),    32'd5);
        check("lim_core_en", 32'(core_en),        32'd0);

        // HALT from HALTED returns to IDLE
        issue(OP_HALT, '0, 32'd0);
        check("to_idle_state",      32'(state),       32'd0);
        check("to_idle_core_reset", 32'(core_reset),  32'd1);
        check("to_idle_retired",    32'(retired_cnt), 32'd0);
        check("to_idle_cause",      32'(halt_cause),  32'd0);

        // Breakpoint at PC 8, then resume with limit 1
        bp_en   = 1'b1;
        bp_addr = 32'd8;
        en_base = en_cnt;
        issue(OP_RUN, '0, 32'd0);
        run_until_stop(20, n);
        check("bp_cycles",  n,                32'd3);
        check("bp_en_cnt",  en_cnt - en_base, 32'd2);
        check("bp_state",   32'(state),       32'd3);
        check("bp_cause",   32'(halt_cause),  32'd2);
        check("bp_retired", 32'(retired_cnt), 32'd2);
        check("bp_pc",      pc_in,            32'd8);
        issue(OP_RUN, '0, 32'd1);
        check("resume_core_en", 32'(core_en), 32'd1);
        run_until_stop(20, n);
        check("resume_cycles",  n,                32'd1);
        check("resume_retired", 32'(retired_cnt), 32'd3);
        check("resume_cause",   32'(halt_cause),  32'd1);
        check("resume_pc",      pc_in,            32'd12);
        bp_en = 1'b0;
        issue(OP_HALT, '0, 32'd0);

        // Three single steps
        for (int k = 1; k <= 3; k++) begin
            issue(OP_STEP, '0, 32'd0);
            check("step_state",   32'(state),            32'd2);
            check("step_ready",   32'(cmd_if.cmd_ready), 32'd0);
            check("step_core_en", 32'(core_en),          32'd1);
            tick();
            check("step_halted",  32'(state),            32'd3);
            check("step_cause",   32'(halt_cause),       32'd3);
            check("step_retired", 32'(retired_cnt),      32'(k));
        end
        issue(OP_HALT, '0, 32'd0);
        check("step_idle_state",      32'(state),       32'd0);
        check("step_idle_core_reset", 32'(core_reset),  32'd1);
        check("step_idle_retired",    32'(retired_cnt), 32'd0);

        // Host HALT accepted after 7 enabled cycles
        en_base = en_cnt;
        issue(OP_RUN, '0, 32'd0);
        tick(6);
        issue(OP_HALT, '0, 32'd0);
        check("host_core_en",  32'(core_en),       32'd0);
        check("host_state",    32'(state),         32'd1);
        tick();
        check("host_halted",   32'(state),         32'd3);
        check("host_cause",    32'(halt_cause),    32'd3);
        check("host_retired",  32'(retired_cnt),   32'd7);
        check("host_en_cnt",   en_cnt - en_base,   32'd7);
        issue(OP_HALT, '0, 32'd0);

        // LOAD during RUN is dropped with an err pulse
        we_base = we_cnt;
        issue(OP_RUN, '0, 32'd0);
        tick();
        issue(OP_LOAD, 8'd9, 32'hdeadbeef);
        check("bad_load_err",     32'(err),     32'd1);
        check("bad_load_we",      32'(imem_we), 32'd0);
        check("bad_load_state",   32'(state),   32'd1);
        check("bad_load_core_en", 32'(core_en), 32'd1);
        tick();
        check("bad_load_err_drop", 32'(err),            32'd0);
        check("bad_load_no_write", we_cnt - we_base,    32'd0);
        issue(OP_HALT, '0, 32'd0);
        tick();
        issue(OP_HALT, '0, 32'd0);

        // Reset mid-RUN at count 4
        issue(OP_RUN, '0, 32'd0);
        tick(4);
        check("mid_rst_count", 32'(retired_cnt), 32'd4);
        reset = 1'b1;
        tick();
        check("mid_rst_state",      32'(state),            32'd0);
        check("mid_rst_core_en",    32'(core_en),          32'd0);
        check("mid_rst_core_reset", 32'(core_reset),       32'd1);
        check("mid_rst_retired",    32'(retired_cnt),      32'd0);
        check("mid_rst_ready",      32'(cmd_if.cmd_ready), 32'd0);
        reset = 1'b0;
        tick();

        // Counter saturates at all-ones (CNT_W=4)
        issue(OP_RUN, '0, 32'd0);
        tick(20);
        check("sat_retired", 32'(retired_cnt), 32'd15);
        check("sat_state",   32'(state),       32'd1);
        check("sat_core_en", 32'(core_en),     32'd1);
        issue(OP_HALT, '0, 32'd0);
        tick();
        check("sat_halt_cause",   32'(halt_cause),  32'd3);
        check("sat_halt_retired", 32'(retired_cnt), 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
